// File: rtl/conv3x3_core.sv
// conv3x3_core: binary-input 3x3 convolution engine.
// Takes one serialized 9-pixel window, accumulates the signed 4-bit taps
// for every pixel that is set, post-processes the sum into a byte and hands
// it to the UART transmitter. The result is held until the transmitter
// reports it done, and bsy back-pressures the window sequencer meanwhile.
//
// Build option:
//   CONV_RELU_EN defined   : ReLU, result clamped to 0..255 (unsigned byte)
//   CONV_RELU_EN undefined : result clamped to -128..127 (two's-complement byte)
module conv3x3_core #(
  parameter logic [35:0]        W    = 36'h111111111,
  parameter logic signed [7:0]  BIAS = 8'sd0,
  parameter int                 NWIN = 676
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strt,
  input  logic       din,
  output logic       bsy,
  output logic [7:0] tx_data,
  output logic       trmt,
  input  logic       tx_done,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACT,
    SEND,
    WAIT
  } state_t;

  // The bias is sign-extended once so LOAD can start from it directly.
  localparam logic signed [9:0] BIAS_EXT = {{2{BIAS[7]}}, BIAS};
  localparam logic [9:0]        WIN_LAST = 10'(NWIN - 1);
  localparam logic [3:0]        TAP_LAST = 4'd8;

  state_t             state_q;
  logic [3:0]         tap_q;
  logic signed [9:0]  acc_q;
  logic signed [9:0]  acc_d;
  logic [9:0]         win_q;
  logic [7:0]         txData_q;
  logic               trmt_q;
  logic               bsy_q;
  logic               frameDone_q;

  logic [3:0]         tapWeight;
  logic signed [9:0]  tapExt;
  logic [7:0]         resByte;

  // Select the weight of the current tap and form the accumulator sum.
  always_comb begin
    tapWeight = W[{tap_q, 2'b00} +: 4];
    tapExt    = {{6{tapWeight[3]}}, tapWeight};
    acc_d     = acc_q + tapExt;
  end

  // Post-process the finished accumulator into the byte that is transmitted.
  always_comb begin
    resByte = acc_q[7:0];
`ifdef CONV_RELU_EN
    if (acc_q[9]) begin
      resByte = 8'h00;
    end else if (acc_q > 10'sd255) begin
      resByte = 8'hFF;
    end
`else
    if (acc_q < -10'sd128) begin
      resByte = 8'h80;
    end else if (acc_q > 10'sd127) begin
      resByte = 8'h7F;
    end
`endif
  end

  // Window sequencing with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= 4'd0;
      acc_q       <= 10'sd0;
      win_q       <= 10'd0;
      txData_q    <= 8'h00;
      trmt_q      <= 1'b0;
      bsy_q       <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strt) begin
            state_q <= LOAD;
            tap_q   <= 4'd0;
            acc_q   <= BIAS_EXT;
            bsy_q   <= 1'b1;
          end
        end
        LOAD: begin
          if (din) begin
            acc_q <= acc_d;
          end
          if (tap_q == TAP_LAST) begin
            tap_q   <= 4'd0;
            state_q <= ACT;
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        ACT: begin
          txData_q <= resByte;
          trmt_q   <= 1'b1;
          state_q  <= SEND;
        end
        SEND: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            state_q <= IDLE;
            bsy_q   <= 1'b0;
            if (win_q == WIN_LAST) begin
              win_q       <= 10'd0;
              frameDone_q <= 1'b1;
            end else begin
              win_q <= win_q + 10'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bsy        = bsy_q;
  assign tx_data    = txData_q;
  assign trmt       = trmt_q;
  assign frame_done = frameDone_q;

endmodule
